// File: rtl/pulse_rect_pkg.sv
// Shared types, widths and helpers for the pulse/rect waveform generator.
// Level width DW, phase counter width TW, slope fraction FR; the ramp
// accumulator carries two guard bits above the Q(DW).FR slope format.
package pulse_rect_pkg;

    localparam int unsigned DW = 12;
    localparam int unsigned TW = 16;
    localparam int unsigned FR = 8;
    localparam int unsigned SW = DW + FR;
    localparam int unsigned AW = DW + FR + 2;

    localparam logic MODE_SINGLE   = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam logic [DW-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_RISE  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_FALL  = 3'd4,
        ST_LOW   = 3'd5
    } state_e;

    // Per-channel configuration, latched as a whole on start.
    typedef struct packed {
        logic          mode;
        logic [DW-1:0] iv;
        logic [DW-1:0] pv;
        logic [TW-1:0] t_delay;
        logic [TW-1:0] t_rise;
        logic [TW-1:0] t_high;
        logic [TW-1:0] t_fall;
        logic [TW-1:0] t_low;
        logic [SW-1:0] slope_r;
        logic [SW-1:0] slope_f;
    } ch_cfg_t;

    // Integer part of a two's-complement accumulator clamped to [0, 2^DW-1].
    function automatic logic [DW-1:0] saturate(input logic [AW-1:0] acc);
        logic [AW-FR-1:0] whole;
        whole = acc[AW-1:FR];
        if (whole[AW-FR-1]) begin
            return '0;
        end else if (|whole[AW-FR-2:DW]) begin
            return LEVEL_MAX;
        end else begin
            return whole[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/pulse_rect_ch.sv
// One waveform channel: phase FSM, down-counter and ramp accumulator.
// Ports: clk, rst_n; start/stop strobes; cfg (config sampled on start);
// out (registered level), busy (not idle), done (single-shot completion pulse).
module pulse_rect_ch
    import pulse_rect_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  ch_cfg_t       cfg,
    output logic [DW-1:0] out,
    output logic          busy,
    output logic          done
);

    state_e        state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] acc, acc_nxt;
    ch_cfg_t       sh, sh_nxt;
    logic [DW-1:0] out_nxt;
    logic          busy_nxt, done_nxt;

    ch_cfg_t       c;
    state_e        ent;
    logic          enter;
    logic [TW-1:0] ent_len;

    // Cycles spent in a phase; LOW never collapses so a period is never empty.
    function automatic logic [TW-1:0] phase_len(input state_e p, input ch_cfg_t k);
        case (p)
            ST_DELAY: return k.t_delay;
            ST_RISE:  return k.t_rise;
            ST_HIGH:  return k.t_high;
            ST_FALL:  return k.t_fall;
            ST_LOW:   return (k.t_low == '0) ? TW'(1) : k.t_low;
            default:  return '0;
        endcase
    endfunction

    // Phase order; IDLE as the origin means "just started".
    function automatic state_e phase_succ(input state_e p, input logic mode);
        case (p)
            ST_IDLE:  return ST_DELAY;
            ST_DELAY: return ST_RISE;
            ST_RISE:  return ST_HIGH;
            ST_HIGH:  return ST_FALL;
            ST_FALL:  return (mode == MODE_PERIODIC) ? ST_LOW : ST_IDLE;
            ST_LOW:   return ST_RISE;
            default:  return ST_IDLE;
        endcase
    endfunction

    // First non-empty phase after 'from' (IDLE reached means single-shot end).
    function automatic state_e next_phase(input state_e from, input ch_cfg_t k);
        state_e p;
        logic   found;
        p     = from;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found) begin
                p     = phase_succ(p, k.mode);
                found = (p == ST_IDLE) || (phase_len(p, k) != '0);
            end
        end
        return p;
    endfunction

    function automatic logic [AW-1:0] level_acc(input logic [DW-1:0] v);
        return {2'b00, v, {FR{1'b0}}};
    endfunction

    function automatic logic [AW-1:0] slope_ext(input logic [SW-1:0] s);
        return {{(AW-SW){s[SW-1]}}, s};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            sh    <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            sh    <= sh_nxt;
            out   <= out_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and next-sample logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        sh_nxt    = sh;
        out_nxt   = out;
        done_nxt  = 1'b0;
        c         = sh;
        ent       = ST_IDLE;
        enter     = 1'b0;
        ent_len   = '0;

        if (stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            out_nxt   = sh.iv;
        end else begin
            if (start) begin
                sh_nxt = cfg;
                c      = cfg;
                enter  = 1'b1;
                ent    = next_phase(ST_IDLE, cfg);
            end else if (state != ST_IDLE) begin
                if (cnt != '0) begin
                    // Stay in phase; the final ramp cycle lands exactly on target.
                    cnt_nxt = cnt - TW'(1);
                    case (state)
                        ST_RISE: begin
                            acc_nxt = acc + slope_ext(sh.slope_r);
                            out_nxt = (cnt == TW'(1)) ? sh.pv : saturate(acc_nxt);
                        end
                        ST_FALL: begin
                            acc_nxt = acc + slope_ext(sh.slope_f);
                            out_nxt = (cnt == TW'(1)) ? sh.iv : saturate(acc_nxt);
                        end
                        ST_HIGH: out_nxt = sh.pv;
                        default: out_nxt = sh.iv;
                    endcase
                end else begin
                    enter = 1'b1;
                    ent   = next_phase(state, sh);
                end
            end

            if (enter) begin
                ent_len   = phase_len(ent, c);
                state_nxt = ent;
                cnt_nxt   = ent_len - TW'(1);
                case (ent)
                    ST_IDLE: begin
                        cnt_nxt  = '0;
                        out_nxt  = c.iv;
                        done_nxt = 1'b1;
                    end
                    ST_RISE: begin
                        acc_nxt = level_acc(c.iv) + slope_ext(c.slope_r);
                        out_nxt = (ent_len == TW'(1)) ? c.pv : saturate(acc_nxt);
                    end
                    ST_FALL: begin
                        acc_nxt = level_acc(c.pv) + slope_ext(c.slope_f);
                        out_nxt = (ent_len == TW'(1)) ? c.iv : saturate(acc_nxt);
                    end
                    ST_HIGH: out_nxt = c.pv;
                    default: out_nxt = c.iv;
                endcase
            end
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: rtl/pulse_rect_gen.sv
// NCH independent pulse/rect waveform channels; the top only slices buses.
// Ports: clk, rst_n; per-channel start/stop/mode; iv/pv levels; five phase
// lengths; rise/fall slopes (signed Q(DW).FR); out samples, busy, done.
module pulse_rect_gen
    import pulse_rect_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH-1:0]    mode,
    input  logic [NCH*DW-1:0] iv,
    input  logic [NCH*DW-1:0] pv,
    input  logic [NCH*TW-1:0] t_delay,
    input  logic [NCH*TW-1:0] t_rise,
    input  logic [NCH*TW-1:0] t_high,
    input  logic [NCH*TW-1:0] t_fall,
    input  logic [NCH*TW-1:0] t_low,
    input  logic [NCH*SW-1:0] slope_r,
    input  logic [NCH*SW-1:0] slope_f,
    output logic [NCH*DW-1:0] out,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ch_cfg_t cfg;

        assign cfg.mode    = mode[g];
        assign cfg.iv      = iv[g*DW +: DW];
        assign cfg.pv      = pv[g*DW +: DW];
        assign cfg.t_delay = t_delay[g*TW +: TW];
        assign cfg.t_rise  = t_rise[g*TW +: TW];
        assign cfg.t_high  = t_high[g*TW +: TW];
        assign cfg.t_fall  = t_fall[g*TW +: TW];
        assign cfg.t_low   = t_low[g*TW +: TW];
        assign cfg.slope_r = slope_r[g*SW +: SW];
        assign cfg.slope_f = slope_f[g*SW +: SW];

        pulse_rect_ch u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start[g]),
            .stop  (stop[g]),
            .cfg   (cfg),
            .out   (out[g*DW +: DW]),
            .busy  (busy[g]),
            .done  (done[g])
        );
    end

endmodule

// File: doc/pulse_rect_gen.md
# pulse_rect_gen

Multi-channel, clocked digital successor to the analogue pulse/rect source macros. Generates NCH independent piecewise-linear waveforms (delay, rise ramp, high, fall ramp, low) as unsigned DW-bit sample streams. Each channel runs single-shot (pulse) or periodic (rect) with programmable per-phase durations and fixed-point ramp slopes. Sits in the digital stimulus path ahead of DAC/behavioural drivers in mixed-signal benches.

## Interface
- NCH, 4, number of channels
- DW, 12, level width (unsigned)
- TW, 16, phase-duration counter width (cycles)
- FR, 8, fractional bits of ramp slope
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  NCH  per-channel start strobe (one cycle)
- stop  in  NCH  per-channel abort strobe
- mode  in  NCH  0 = single pulse, 1 = periodic rect
- iv, pv  in  NCH*DW  initial / pulsed level
- t_delay, t_rise, t_high, t_fall, t_low  in  NCH*TW  phase lengths in cycles
- slope_r, slope_f  in  NCH*(DW+FR)  signed per-cycle increment, Q(DW).FR
- out  out  NCH*DW  registered sample
- busy  out  NCH  channel not IDLE
- done  out  NCH  one-cycle pulse on single-shot completion

## Operation
- States per channel: IDLE, DELAY, RISE, HIGH, FALL, LOW.
- On start (and not stop): all config inputs latched into shadow registers; later input changes ignored until next start. Start while busy restarts from DELAY with new config.
- stop wins over simultaneous start: next cycle state IDLE, out = latched iv, no done.
- Phase order: DELAY → RISE → HIGH → FALL → (mode 0: IDLE, done; mode 1: LOW → RISE ...). DELAY occurs once per start only.
- Phase with length 0 is skipped (zero cycles). In mode 1, LOW length is max(t_low,1) so a period is never empty.
- DELAY, LOW, IDLE: out = iv. HIGH: out = pv.
- RISE cycle k of n: accumulator (DW+FR+2 bits, signed) starts at iv<<FR, adds slope_r each cycle; out = saturate(acc>>FR) to [0, 2^DW−1]; cycle k=n forces out = pv exactly. FALL identical with slope_f, last cycle forces iv.
- After single-shot completion out holds iv, busy = 0.

## Timing
- Reset: state IDLE, out = 0, busy = 0, done = 0, shadows 0.
- start sampled at edge E0; first cycle of first non-skipped phase visible on out after E0 (latency 1); busy = 1 from E0+.
- Each phase of length L occupies exactly L clock cycles of out.
- done asserts the cycle after the last FALL (or last non-skipped) cycle, coincident with busy falling; single cycle.
- Reset mid-operation: immediate return to reset values, regardless of phase.
- Counters count down L−1 … 0; TW-bit max length 2^TW−1, no wrap.
- Channels fully independent; no cross-channel interaction.

## Structure
- Package pulse_rect_pkg: state enum, MODE_SINGLE/MODE_PERIODIC constants, saturate function.
- Sub-module pulse_rect_ch (one channel FSM + counter + accumulator), instantiated NCH times by generate; top only slices buses.

## Test plan
- Single: iv=0, pv=1000, t_delay=3, t_rise=4, slope_r=250<<8, t_high=5, t_fall=2, slope_f=−500<<8 → out 0×3, 250,500,750,1000, 1000×5, 500,0; done one cycle later.
- Periodic: t_delay=0, t_rise=0, t_high=2, t_fall=0, t_low=0 → out pv,pv,iv repeating (period 3), busy stays 1, no done.
- Saturation: iv=4000, pv=4095, slope_r=200<<8, t_rise=3 → 4095,4095,4095 (clamped, last forced pv).
- stop and start in same cycle mid-HIGH → next cycle IDLE, out=iv, no done; start alone while busy → restart from DELAY with new config.
- rst_n low mid-RISE (asynchronous, off-edge) → out=0, busy=0 immediately; release then start → normal sequence.
- Two channels with different modes started same cycle → waveforms match individual runs exactly.
